mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 41 ++++
 rtl/rr_arb2.sv | 32 +++
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter:
// FSM state encoding, store/load type codes, and small decode helpers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] SL_LB   = 4'b0000;
    localparam logic [3:0] SL_LH   = 4'b0001;
    localparam logic [3:0] SL_LW   = 4'b0010;
    localparam logic [3:0] SL_SB   = 4'b1000;
    localparam logic [3:0] SL_SH   = 4'b1001;
    localparam logic [3:0] SL_SW   = 4'b1010;
    localparam logic [3:0] SL_IDLE = 4'b1111;

    // True for the six legal store/load codes
    function automatic logic sl_defined(input logic [3:0] sl);
        case (sl)
            SL_LB, SL_LH, SL_LW, SL_SB, SL_SH, SL_SW: sl_defined = 1'b1;
            default:                                  sl_defined = 1'b0;
        endcase
    endfunction

    // Stores are the legal codes with bit 3 set
    function automatic logic sl_is_store(input logic [3:0] sl);
        sl_is_store = sl_defined(sl) & sl[3];
    endfunction

    // Access width in bytes (only meaningful for legal codes)
    function automatic logic [2:0] sl_size(input logic [3:0] sl);
        case (sl[1:0])
            2'b00:   sl_size = 3'd1;
            2'b01:   sl_size = 3'd2;
            default: sl_size = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter. The grant is combinational; the
// last_grant register only moves when the caller reports an accept.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic       grant
);

    logic last_grant_reg;

    // A lone requester wins; on a tie (or no request) favour the port not served last
    always_comb begin
        grant = ~last_grant_reg;
        if (valid == 2'b01) begin
            grant = 1'b0;
        end else if (valid == 2'b10) begin
            grant = 1'b1;
        end
    end

    // Remember the winner; reset to 1 so port 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
        end else if (accept) begin
            last_grant_reg <= grant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter: IDLE accepts one request, ACCESS
// drives the memory for one cycle, RESP pulses rvalid to the winner.
// Optional macro MEM_ARB_ALIGN_CHK_EN rejects misaligned or out-of-range
// accesses with err=1 and no memory cycle.
import mem_arb_pkg::*;

module mem_arbiter #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    input  logic [3:0]  req0_sltype,
    output logic        req0_rvalid,
    output logic [31:0] req0_rdata,
    output logic        req0_err,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    input  logic [3:0]  req1_sltype,
    output logic        req1_rvalid,
    output logic [31:0] req1_rdata,
    output logic        req1_err,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic        mem_we,
    output logic [3:0]  mem_sltype,
    input  logic [31:0] mem_rd
);

    state_t      state_reg, state_next;
    logic        grant;
    logic        accept;
    logic [1:0]  valid_vec;
    logic [1:0]  ready_vec;
    logic [1:0]  rvalid_vec;
    logic [31:0] addr_sel, wdata_sel;
    logic [3:0]  sl_sel;
    logic        bad_sel;

    logic [31:0] addr_reg, wdata_reg;
    logic [3:0]  sltype_reg;
    logic        port_reg;
    logic        bad_reg;
    logic [31:0] rdata_reg [2];
    logic        err_reg   [2];

    assign valid_vec = {req1_valid, req0_valid};

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid_vec),
        .accept (accept),
        .grant  (grant)
    );

    // Per-port handshake and completion, plus the held response registers
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign ready_vec[gi]  = (state_reg == IDLE) & valid_vec[gi] & (grant == 1'(gi)) & ~rst;
            assign rvalid_vec[gi] = (state_reg == RESP) & (port_reg == 1'(gi));

            // Capture load data (or 0 for stores / rejected accesses) at the end of ACCESS
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdata_reg[gi] <= 32'd0;
                    err_reg[gi]   <= 1'b0;
                end else if (state_reg == ACCESS && port_reg == 1'(gi)) begin
                    rdata_reg[gi] <= (bad_reg | sl_is_store(sltype_reg)) ? 32'd0 : mem_rd;
                    err_reg[gi]   <= bad_reg;
                end
            end
        end
    endgenerate

    assign accept      = |ready_vec;
    assign req0_ready  = ready_vec[0];
    assign req1_ready  = ready_vec[1];
    assign req0_rvalid = rvalid_vec[0];
    assign req1_rvalid = rvalid_vec[1];
    assign req0_rdata  = rdata_reg[0];
    assign req1_rdata  = rdata_reg[1];
    assign req0_err    = err_reg[0];
    assign req1_err    = err_reg[1];

    assign addr_sel  = grant ? req1_addr   : req0_addr;
    assign wdata_sel = grant ? req1_wdata  : req0_wdata;
    assign sl_sel    = grant ? req1_sltype : req0_sltype;

`ifdef MEM_ARB_ALIGN_CHK_EN
    logic [32:0] last_byte;
    logic        misaligned;
    logic        out_of_range;

    // Reject undefined codes, misaligned halves/words and accesses running off the memory
    always_comb begin
        last_byte    = {1'b0, addr_sel} + 33'(sl_size(sl_sel)) - 33'd1;
        misaligned   = ((sl_sel[1:0] == 2'b01) & addr_sel[0]) |
                       ((sl_sel[1:0] == 2'b10) & (addr_sel[1:0] != 2'b00));
        out_of_range = (last_byte >= 33'(MEM_BYTES));
        bad_sel      = ~sl_defined(sl_sel) | misaligned | out_of_range;
    end
`else
    // Addresses pass through unchecked; only undefined codes are rejected
    always_comb begin
        bad_sel = ~sl_defined(sl_sel);
    end
`endif

    // Latch the winning request so the requester is free after ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_reg   <= 32'd0;
            wdata_reg  <= 32'd0;
            sltype_reg <= 4'd0;
            port_reg   <= 1'b0;
            bad_reg    <= 1'b0;
        end else if (accept) begin
            addr_reg   <= addr_sel;
            wdata_reg  <= wdata_sel;
            sltype_reg <= sl_sel;
            port_reg   <= grant;
            bad_reg    <= bad_sel;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: fixed three-cycle walk once a request is accepted
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory port: active only in ACCESS; rejected accesses look idle to the memory
    always_comb begin
        mem_a      = 32'd0;
        mem_wd     = 32'd0;
        mem_we     = 1'b0;
        mem_sltype = SL_IDLE;
        if (state_reg == ACCESS) begin
            mem_a  = addr_reg;
            mem_wd = wdata_reg;
            if (!bad_reg) begin
                mem_sltype = sltype_reg;
                mem_we     = sl_is_store(sltype_reg);
            end
        end
    end

endmodule
